// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : scan_pkg
// Brief  : Shared types and default timing constants for the LiDAR head scan
//          sequencer and the servo PWM generators, so both agree on the frame
//          period and the duty-word encoding.
// Rev    : 1.0  initial release
// ============================================================================
package scan_pkg;

  // Duty word written to the servo PWM generators.
  typedef logic [31:0] duty_t;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVE    = 3'd1,
    S_SETTLE  = 3'd2,
    S_SAMPLE  = 3'd3,
    S_ADVANCE = 3'd4,
    S_PARK    = 3'd5
  } scan_state_t;

  // Default timing constants. The PWM generator wraps at the same
  // FRAME_TICKS, so a frame is FRAME_TICKS+1 clocks in both blocks.
  localparam int unsigned DEF_FRAME_TICKS   = 2000000;
  localparam int unsigned DEF_PULSE_MIN     = 100000;
  localparam int unsigned DEF_PULSE_STEP    = 5555;
  localparam int unsigned DEF_YAW_STEPS     = 181;
  localparam int unsigned DEF_PITCH_STEPS   = 46;
  localparam int unsigned DEF_SETTLE_FRAMES = 3;
  localparam int unsigned DEF_PARK_DUTY     = 150000;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module : frame_timer
// Brief  : Free-running frame counter 0..FRAME_TICKS. frame_end_o is high
//          during the last cycle of each frame, so logic registering on it
//          updates in the first cycle of the next frame (counter = 0).
// Ports  : clk          in   clock
//          reset        in   synchronous, active-high reset (counter -> 0)
//          frame_end_o  out  high when counter == FRAME_TICKS
// Rev    : 1.0  initial release
// ============================================================================
module frame_timer
  import scan_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = DEF_FRAME_TICKS
) (
  input  logic clk,
  input  logic reset,
  output logic frame_end_o
);

  localparam int unsigned c_cnt_w = (FRAME_TICKS > 0) ? $clog2(FRAME_TICKS + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FRAME_TICKS);

  logic [c_cnt_w-1:0] count_q;
  logic [c_cnt_w-1:0] count_d;
  logic               w_frame_end;

  always_comb begin
    w_frame_end = (count_q == c_last);
    count_d     = w_frame_end ? '0 : count_q + c_cnt_w'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign frame_end_o = w_frame_end;

endmodule : frame_timer
`default_nettype wire

// File: rtl/servo_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module : servo_scan_sequencer
// Brief  : Raster-scan sequencer for the LiDAR head yaw/pitch servos. Duty
//          words change only in the first cycle of a frame; each grid point
//          is held for SETTLE_FRAMES frames, then a sample is requested and
//          the scan advances on acknowledge. Duty words are kept in
//          incremental accumulators (duty = PULSE_MIN + idx*PULSE_STEP).
// Config : SCAN_SERPENTINE_EN - when defined, odd pitch rows traverse yaw in
//          descending order instead of restarting at index 0.
// Ports  : clk, reset            clock, synchronous active-high reset
//          start_i, abort_i      scan start / abort pulses
//          sample_ack_i          LiDAR capture accepted the point
//          yaw_duty_o            duty word to yaw PWM generator
//          pitch_duty_o          duty word to pitch PWM generator
//          sample_req_o          sample request at the current point
//          yaw_idx_o/pitch_idx_o current grid indices
//          busy_o                high outside IDLE
//          done_o                one-cycle pulse at completion or abort
// Rev    : 1.0  initial release
// ============================================================================
module servo_scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned FRAME_TICKS   = DEF_FRAME_TICKS,
  parameter int unsigned PULSE_MIN     = DEF_PULSE_MIN,
  parameter int unsigned PULSE_STEP    = DEF_PULSE_STEP,
  parameter int unsigned YAW_STEPS     = DEF_YAW_STEPS,
  parameter int unsigned PITCH_STEPS   = DEF_PITCH_STEPS,
  parameter int unsigned SETTLE_FRAMES = DEF_SETTLE_FRAMES,
  parameter int unsigned PARK_DUTY     = DEF_PARK_DUTY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        sample_ack_i,
  output logic [31:0] yaw_duty_o,
  output logic [31:0] pitch_duty_o,
  output logic        sample_req_o,
  output logic [7:0]  yaw_idx_o,
  output logic [7:0]  pitch_idx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam duty_t      c_pulse_min  = duty_t'(PULSE_MIN);
  localparam duty_t      c_step       = duty_t'(PULSE_STEP);
  localparam duty_t      c_park       = duty_t'(PARK_DUTY);
  localparam logic [7:0] c_yaw_last   = 8'(YAW_STEPS - 1);
  localparam logic [7:0] c_pitch_last = 8'(PITCH_STEPS - 1);
  localparam logic [7:0] c_settle     = 8'(SETTLE_FRAMES);

  logic w_frame_end;

  frame_timer #(
    .FRAME_TICKS (FRAME_TICKS)
  ) u_frame_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_end_o (w_frame_end)
  );

  scan_state_t state_q, state_d;
  logic [7:0]  yaw_idx_q, yaw_idx_d;
  logic [7:0]  pitch_idx_q, pitch_idx_d;
  duty_t       yaw_acc_q, yaw_acc_d;
  duty_t       pitch_acc_q, pitch_acc_d;
  duty_t       yaw_duty_q, yaw_duty_d;
  duty_t       pitch_duty_q, pitch_duty_d;
  logic [7:0]  settle_q, settle_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic        w_rev;      // current row runs yaw downwards
  logic        w_row_end;  // yaw index at the last point of this row

  always_comb begin
    state_d      = state_q;
    yaw_idx_d    = yaw_idx_q;
    pitch_idx_d  = pitch_idx_q;
    yaw_acc_d    = yaw_acc_q;
    pitch_acc_d  = pitch_acc_q;
    yaw_duty_d   = yaw_duty_q;
    pitch_duty_d = pitch_duty_q;
    settle_d     = settle_q;
    req_d        = 1'b0;
    done_d       = 1'b0;

`ifdef SCAN_SERPENTINE_EN
    w_rev = pitch_idx_q[0];
`else
    w_rev = 1'b0;
`endif
    w_row_end = w_rev ? (yaw_idx_q == 8'd0) : (yaw_idx_q == c_yaw_last);

    case (state_q)
      S_IDLE: begin
        // Start wins over a coincident abort simply because abort is not
        // looked at here.
        if (start_i) begin
          yaw_idx_d   = 8'd0;
          pitch_idx_d = 8'd0;
          yaw_acc_d   = c_pulse_min;
          pitch_acc_d = c_pulse_min;
          state_d     = S_MOVE;
        end
      end

      S_MOVE: begin
        if (abort_i) begin
          state_d = S_PARK;
        end else if (w_frame_end) begin
          yaw_duty_d   = yaw_acc_q;
          pitch_duty_d = pitch_acc_q;
          settle_d     = 8'd0;
          state_d      = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort_i) begin
          state_d = S_PARK;
        end else if (w_frame_end) begin
          settle_d = settle_q + 8'd1;
          if (settle_q + 8'd1 == c_settle) begin
            state_d = S_SAMPLE;
          end
        end
      end

      S_SAMPLE: begin
        // Request rises one cycle after entry; an ack is only honoured
        // while the request is already visible.
        if (abort_i) begin
          state_d = S_PARK;
        end else if (req_q && sample_ack_i) begin
          state_d = S_ADVANCE;
        end else begin
          req_d = 1'b1;
        end
      end

      S_ADVANCE: begin
        if (abort_i) begin
          state_d = S_PARK;
        end else if (!w_row_end) begin
          if (w_rev) begin
            yaw_idx_d = yaw_idx_q - 8'd1;
            yaw_acc_d = yaw_acc_q - c_step;
          end else begin
            yaw_idx_d = yaw_idx_q + 8'd1;
            yaw_acc_d = yaw_acc_q + c_step;
          end
          state_d = S_MOVE;
        end else if (pitch_idx_q < c_pitch_last) begin
          pitch_idx_d = pitch_idx_q + 8'd1;
          pitch_acc_d = pitch_acc_q + c_step;
`ifndef SCAN_SERPENTINE_EN
          yaw_idx_d   = 8'd0;
          yaw_acc_d   = c_pulse_min;
`endif
          state_d     = S_MOVE;
        end else begin
          state_d = S_PARK;
        end
      end

      S_PARK: begin
        if (w_frame_end) begin
          yaw_duty_d   = c_park;
          pitch_duty_d = c_park;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      yaw_idx_q    <= 8'd0;
      pitch_idx_q  <= 8'd0;
      yaw_acc_q    <= c_pulse_min;
      pitch_acc_q  <= c_pulse_min;
      yaw_duty_q   <= c_park;
      pitch_duty_q <= c_park;
      settle_q     <= 8'd0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      yaw_idx_q    <= yaw_idx_d;
      pitch_idx_q  <= pitch_idx_d;
      yaw_acc_q    <= yaw_acc_d;
      pitch_acc_q  <= pitch_acc_d;
      yaw_duty_q   <= yaw_duty_d;
      pitch_duty_q <= pitch_duty_d;
      settle_q     <= settle_d;
      req_q        <= req_d;
      done_q       <= done_d;
    end
  end

  assign yaw_duty_o   = yaw_duty_q;
  assign pitch_duty_o = pitch_duty_q;
  // Abort withdraws the request in the very cycle it is seen.
  assign sample_req_o = req_q & ~abort_i;
  assign yaw_idx_o    = yaw_idx_q;
  assign pitch_idx_o  = pitch_idx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;

endmodule : servo_scan_sequencer
`default_nettype wire

// File: tb/tb_servo_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_servo_scan_sequencer
// Brief  : Directed self-checking bench for servo_scan_sequencer with
//          FRAME_TICKS=99 (100-cycle frames), 3x2 grid, 2 settle frames.
//          cyc counts rising edges since reset release; the frame counter
//          equals cyc mod 100, so duty loads land on multiples of 100.
// Rev    : 1.0  initial release
// ============================================================================
module tb_servo_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        abort_i;
  logic        sample_ack_i;
  logic [31:0] yaw_duty_o;
  logic [31:0] pitch_duty_o;
  logic        sample_req_o;
  logic [7:0]  yaw_idx_o;
  logic [7:0]  pitch_idx_o;
  logic        busy_o;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int req_seen = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  servo_scan_sequencer #(
    .FRAME_TICKS   (99),
    .PULSE_MIN     (10),
    .PULSE_STEP    (5),
    .YAW_STEPS     (3),
    .PITCH_STEPS   (2),
    .SETTLE_FRAMES (2),
    .PARK_DUTY     (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .sample_ack_i (sample_ack_i),
    .yaw_duty_o   (yaw_duty_o),
    .pitch_duty_o (pitch_duty_o),
    .sample_req_o (sample_req_o),
    .yaw_idx_o    (yaw_idx_o),
    .pitch_idx_o  (pitch_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always @(negedge clk) begin
    if (sample_req_o) req_seen++;
    if (done_o)       done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_yaw_duty"},   yaw_duty_o,   32'd20);
    chk({pfx, "_pitch_duty"}, pitch_duty_o, 32'd20);
    chk({pfx, "_req"},        {31'd0, sample_req_o}, 32'd0);
    chk({pfx, "_busy"},       {31'd0, busy_o}, 32'd0);
    chk({pfx, "_done"},       {31'd0, done_o}, 32'd0);
    chk({pfx, "_yaw_idx"},    {24'd0, yaw_idx_o},   32'd0);
    chk({pfx, "_pitch_idx"},  {24'd0, pitch_idx_o}, 32'd0);
  endtask

  int exp_yaw_idx [6];
  int prev_yaw, prev_pitch, d0, bad;

  initial begin
`ifdef SCAN_SERPENTINE_EN
    exp_yaw_idx = '{0, 1, 2, 2, 1, 0};
`else
    exp_yaw_idx = '{0, 1, 2, 0, 1, 2};
`endif
    reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; sample_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    cyc = 0;

    // Idle: park duty held, no requests.
    goto(500);
    chk("idle_yaw_duty",   yaw_duty_o,   32'd20);
    chk("idle_pitch_duty", pitch_duty_o, 32'd20);
    chk("idle_busy",       {31'd0, busy_o}, 32'd0);
    chk("idle_req_seen",   req_seen, 0);

    // Full scan, start pulse on cycle 537.
    goto(536);
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    prev_yaw = 20; prev_pitch = 20;
    for (int k = 0; k < 6; k++) begin
      goto(599 + 300*k);
      chk("pre_load_yaw",   yaw_duty_o,   prev_yaw);
      chk("pre_load_pitch", pitch_duty_o, prev_pitch);
      step();
      chk("load_yaw_duty",   yaw_duty_o,   10 + 5*exp_yaw_idx[k]);
      chk("load_pitch_duty", pitch_duty_o, 10 + 5*(k/3));
      chk("load_yaw_idx",    {24'd0, yaw_idx_o},   exp_yaw_idx[k]);
      chk("load_pitch_idx",  {24'd0, pitch_idx_o}, k/3);
      prev_yaw = 10 + 5*exp_yaw_idx[k]; prev_pitch = 10 + 5*(k/3);
      goto(800 + 300*k);
      chk("sample_entry_req", {31'd0, sample_req_o}, 32'd0);
      // An ack present before the request is up must be ignored.
      if (k == 0) sample_ack_i = 1'b1;
      step();
      chk("req_high", {31'd0, sample_req_o}, 32'd1);
      sample_ack_i = 1'b1;
      step();
      chk("req_drop_on_ack", {31'd0, sample_req_o}, 32'd0);
      sample_ack_i = 1'b0;
    end
    goto(2399);
    chk("pre_done", {31'd0, done_o}, 32'd0);
    chk("park_busy", {31'd0, busy_o}, 32'd1);
    d0 = done_cnt;
    step();
    chk("done_pulse", {31'd0, done_o}, 32'd1);
    chk("done_yaw_duty",   yaw_duty_o,   32'd20);
    chk("done_pitch_duty", pitch_duty_o, 32'd20);
    chk("done_busy", {31'd0, busy_o}, 32'd0);
    step();
    chk("done_one_cycle", {31'd0, done_o}, 32'd0);
    chk("done_count_scan", done_cnt - d0, 1);

    // Abort while the request is high.
    goto(2436);
    start_i = 1'b1; step(); start_i = 1'b0;
    goto(2701);
    chk("abort_req_before", {31'd0, sample_req_o}, 32'd1);
    abort_i = 1'b1;
    #1;
    chk("abort_req_same_cycle", {31'd0, sample_req_o}, 32'd0);
    d0 = done_cnt;
    step();
    abort_i = 1'b0;
    chk("abort_req_next", {31'd0, sample_req_o}, 32'd0);
    chk("abort_busy_park", {31'd0, busy_o}, 32'd1);
    goto(2799);
    chk("abort_hold_yaw", yaw_duty_o, 32'd10);
    step();
    chk("abort_done", {31'd0, done_o}, 32'd1);
    chk("abort_park_yaw",   yaw_duty_o,   32'd20);
    chk("abort_park_pitch", pitch_duty_o, 32'd20);
    goto(2830);
    chk("abort_busy_low", {31'd0, busy_o}, 32'd0);
    chk("abort_done_count", done_cnt - d0, 1);

    // Ack withheld for 5 frames at the second point, then reset.
    goto(2836);
    start_i = 1'b1; step(); start_i = 1'b0;
    goto(3101);
    sample_ack_i = 1'b1; step(); sample_ack_i = 1'b0;
    goto(3401);
    chk("hold_req_start", {31'd0, sample_req_o}, 32'd1);
    chk("hold_yaw_idx",   {24'd0, yaw_idx_o}, 32'd1);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (sample_req_o !== 1'b1 || yaw_duty_o !== 32'd15 || pitch_duty_o !== 32'd10) bad++;
    end
    chk("hold_stable_cycles_bad", bad, 0);
    reset = 1'b1;
    step();
    chk_reset_outputs("midreset");
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_servo_scan_sequencer
`default_nettype wire

// File: doc/servo_scan_sequencer.md
# servo_scan_sequencer

Sequences the yaw and pitch servo PWM generators through a raster scan for the LiDAR head. Drives the two 32-bit duty-cycle words, updating them only on 20 ms frame boundaries, and waits a settle interval at each grid point. Then issues a sample request to the LiDAR capture logic and advances on acknowledge. Sits between the CPU-visible control registers and the two PWM generator instances; shares their clock and reset so its frame counter stays phase-aligned with theirs.

## Interface
- FRAME_TICKS, 2000000: terminal count of the frame counter; frame period is FRAME_TICKS+1 cycles, identical to the PWM generator wrap.
- PULSE_MIN, 100000: duty word at index 0.
- PULSE_STEP, 5555: duty increment per grid index.
- YAW_STEPS, 181: yaw grid points per row (1..256).
- PITCH_STEPS, 46: pitch rows (1..256).
- SETTLE_FRAMES, 3: frames to wait after each move (1..255).
- PARK_DUTY, 150000: duty word for both axes when not scanning.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start_i  in  1  pulse; begins a scan when idle.
- abort_i  in  1  pulse; terminates a scan.
- sample_ack_i  in  1  LiDAR capture accepted the point.
- yaw_duty_o  out  32  duty word to yaw PWM generator.
- pitch_duty_o  out  32  duty word to pitch PWM generator.
- sample_req_o  out  1  request for a sample at the current point.
- yaw_idx_o  out  8  current yaw index.
- pitch_idx_o  out  8  current pitch index.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse at scan completion or abort.

## Operation
- Free-running frame counter 0..FRAME_TICKS; frame_end = (count == FRAME_TICKS).
- States: IDLE, MOVE, SETTLE, SAMPLE, ADVANCE, PARK.
- IDLE: duty outputs = PARK_DUTY. On start_i: indices <= 0; -> MOVE.
- MOVE: on frame_end, load yaw_duty_o/pitch_duty_o from the internal duty accumulators; settle count <= 0; -> SETTLE.
- SETTLE: increment on each frame_end. When it reaches SETTLE_FRAMES -> SAMPLE.
- SAMPLE: sample_req_o = 1. On a cycle with sample_ack_i = 1, drop the request -> ADVANCE.
- ADVANCE, one cycle:
  - If yaw_idx < YAW_STEPS-1: yaw_idx+1, yaw accumulator +PULSE_STEP.
  - Else, if pitch_idx < PITCH_STEPS-1: yaw wraps, pitch_idx+1, pitch accumulator +PULSE_STEP.
  - Else the scan is complete -> PARK.
  - Otherwise -> MOVE.
- Duty accumulators are updated incrementally (add/subtract PULSE_STEP), with no multiplier; on a yaw wrap the yaw accumulator reloads PULSE_MIN. Invariant: duty = PULSE_MIN + idx*PULSE_STEP in 32-bit unsigned.
- PARK: on frame_end load PARK_DUTY on both axes, pulse done_o -> IDLE.
- abort_i in MOVE/SETTLE/SAMPLE/ADVANCE: sample_req_o drops the same cycle -> PARK. abort_i in IDLE/PARK is ignored.
- start_i when not IDLE is ignored. start_i and abort_i in the same IDLE cycle: start wins.

## Timing
- Reset values:
  - Outputs: yaw_duty_o = pitch_duty_o = PARK_DUTY; sample_req_o, busy_o and done_o = 0; indices = 0.
  - Internals: frame counter = 0, state = IDLE.
- Duty outputs are registered and change only in the cycle after frame_end, i.e. coincident with PWM counter = 0, so no truncated pulse occurs.
- sample_req_o asserts the cycle after entering SAMPLE and stays high until ack is sampled. An ack arriving while req is low is ignored.
- Minimum dwell per point: SETTLE_FRAMES full frames after the duty update, plus ack latency.
- done_o is coincident with the PARK duty load.
- Reset mid-scan returns all outputs to reset values in the next cycle.

## Configuration
- SCAN_SERPENTINE_EN defined: odd pitch rows traverse yaw in descending order. The yaw index and accumulator reverse direction (subtract PULSE_STEP) instead of wrapping to 0, so there is no full-width yaw slew between rows.
- Not defined: every row starts at yaw_idx 0 / PULSE_MIN.

## Structure
- Shared package scan_pkg: state enum scan_state_t and the 32-bit duty_t typedef. Default timing constants also go there, so the PWM generator and the sequencer agree on FRAME_TICKS.
- Sub-module frame_timer: frame counter with frame_end output, reusable by other frame-synchronous logic.

## Test plan
Parameters for all scenarios: FRAME_TICKS=99, YAW_STEPS=3, PITCH_STEPS=2, SETTLE_FRAMES=2, PULSE_MIN=10, PULSE_STEP=5, PARK_DUTY=20; ack one cycle after req.
- Reset then idle 500 cycles -> both duties 20, busy_o=0, sample_req_o never high.
- start_i at cycle 37 -> duties become 10/10 only at frame counter 0 (cycle 100). First sample_req_o after 2 further frame_ends.
- Full scan -> yaw duty sequence 10,15,20,10,15,20; pitch 10,10,10,15,15,15; 6 acks; then done_o pulse with duties 20/20 at a frame boundary.
- Same scan with SCAN_SERPENTINE_EN -> yaw sequence 10,15,20,20,15,10.
- abort_i while sample_req_o high -> req low the next cycle, park at next frame boundary, done_o once, busy_o low.
- Ack held low for 5 frames in SAMPLE -> req stays high and duties stay unchanged; reset mid-SAMPLE -> all outputs at reset values.
